alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The block SHALL have parameter: XLEN, 32, operand/result width (only 32 is supported; shift amount is op_b[4:0]).
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 The block SHALL have port: valid_in  input  1  operation request.
REQ-005 The block SHALL have port: ready_in  output  1  block can accept an operation this cycle.
REQ-006 The block SHALL have port: ALU_ctl  input  `ALU_CONTROL_WIDTH  operation code from the ALU control decoder (`ALU_ADD/SUB/XOR/OR/AND/SLL/SRL/LT/NULL).
REQ-007 The block SHALL have ports: op_a, op_b  input  XLEN  source operands.
REQ-008 The block SHALL have port: valid_out  output  1  one-cycle pulse, result valid.
REQ-009 The block SHALL have port: result  output  XLEN  operation result; held until the next valid_out.
REQ-010 The block SHALL have port: zero  output  1  result == 0; held with result.

Function
REQ-011 The block SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 ready_in SHALL be 1 in IDLE and DONE, and 0 in SHIFT.
REQ-013 An operation SHALL be accepted only on a rising edge where valid_in && ready_in; ALU_ctl, op_a, op_b SHALL be captured internally on acceptance, and input changes afterwards SHALL have no effect.
REQ-014 ADD/SUB/XOR/OR/AND SHALL compute mod 2^32, and the FSM SHALL go to DONE on the acceptance edge (latency 1: valid_out high the cycle after acceptance).
REQ-015 LT SHALL produce 32'd1 if signed op_a < signed op_b, else 32'd0, with latency 1.
REQ-016 NULL, or any unlisted code, SHALL produce 32'd0 with latency 1.
REQ-017 SLL/SRL (logical, zero fill) SHALL load a working register with op_a and a 5-bit counter with op_b[4:0]; bits op_b[31:5] SHALL be ignored.
REQ-018 For SLL/SRL with shamt = 0, the FSM SHALL go straight to DONE (latency 1, result = op_a).
REQ-019 For SLL/SRL with shamt > 0, the FSM SHALL enter SHIFT, shifting one bit and decrementing the counter each cycle, and go to DONE on the edge where the counter reaches 0; latency = shamt + 1 cycles (31 -> 32 cycles).
REQ-020 DONE SHALL last exactly one cycle, with valid_out = 1 and result/zero updated on entry to DONE.
REQ-021 From DONE, the FSM SHALL go to IDLE, or accept a new operation directly when valid_in is high (back-to-back single-cycle operations yield one result per cycle).
REQ-022 valid_in asserted during SHIFT SHALL be ignored (not queued); the requester SHALL hold valid_in until ready_in.
REQ-023 valid_out SHALL be 0 in IDLE and SHIFT.

Reset
REQ-024 While rst_n = 0, the block SHALL be in IDLE with valid_out = 0, result = 0, zero = 1, ready_in = 1, and the internal counter and working register = 0.
REQ-025 Reset asserted mid-SHIFT SHALL abort the operation immediately, with no valid_out for that operation.
REQ-026 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-027 Reset, then ADD a=0xFFFFFFFF, b=1 -> valid_out pulse after 1 cycle, result 0x00000000, zero 1.
REQ-028 LT a=0xFFFFFFFE (-2), b=1 -> result 1; SUB a=5, b=5 -> result 0, zero 1.
REQ-029 SLL a=0x00000001, b=0x0000003F (shamt 31) -> ready_in low for 31 cycles, valid_out 32 cycles after acceptance, result 0x80000000; valid_in pulsed during SHIFT is ignored.
REQ-030 SRL a=0x80000000, b=0 -> latency 1, result 0x80000000; SRL b=4 -> result 0x08000000 after 5 cycles.
REQ-031 Four back-to-back XOR/OR/AND/NULL operations with valid_in held high -> four consecutive valid_out pulses with correct results, NULL giving 0, zero 1.
REQ-032 Assert rst_n low at cycle 3 of an SLL shamt=10 -> no valid_out; after release, result 0, zero 1, and the next ADD completes normally.

Source files
------------

// File: rtl/alu_iter.sv
// alu_iter: small iterative ALU. Single-cycle ops (add/sub/logic/lt/null)
// finish on the acceptance edge; logical shifts walk one bit per cycle
// through a working register.
//
// Handshake: an operation is accepted on a rising edge where
// valid_in && ready_in. ready_in is low only while a shift is in progress,
// and valid_in seen during that time is dropped, not queued. valid_out is a
// one-cycle pulse; result/zero hold until the next pulse.

`ifndef ALU_CONTROL_WIDTH
`define ALU_CONTROL_WIDTH 4
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_XOR  4'd2
`define ALU_OR   4'd3
`define ALU_AND  4'd4
`define ALU_SLL  4'd5
`define ALU_SRL  4'd6
`define ALU_LT   4'd7
`define ALU_NULL 4'd8
`endif

module alu_iter #(
    parameter int XLEN = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_in,
    output logic                          ready_in,
    input  logic [`ALU_CONTROL_WIDTH-1:0] ALU_ctl,
    input  logic [XLEN-1:0]               op_a,
    input  logic [XLEN-1:0]               op_b,
    output logic                          valid_out,
    output logic [XLEN-1:0]               result,
    output logic                          zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] work;
    logic [4:0]      cnt;
    logic            shift_right;

    logic [XLEN-1:0] comb_val;
    logic            is_shift;
    logic            is_srl;
    logic [4:0]      shamt;
    logic [XLEN-1:0] work_next;

    // Only SHIFT blocks new requests.
    assign ready_in = (state != SHIFT);
    assign shamt    = op_b[4:0];

    // Decode the incoming operation; shifts with shamt 0 pass op_a through.
    always_comb begin
        comb_val = '0;
        is_shift = 1'b0;
        is_srl   = 1'b0;
        case (ALU_ctl)
            `ALU_ADD: comb_val = op_a + op_b;
            `ALU_SUB: comb_val = op_a - op_b;
            `ALU_XOR: comb_val = op_a ^ op_b;
            `ALU_OR:  comb_val = op_a | op_b;
            `ALU_AND: comb_val = op_a & op_b;
            `ALU_LT:  comb_val = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            `ALU_SLL: begin
                is_shift = 1'b1;
                comb_val = op_a;
            end
            `ALU_SRL: begin
                is_shift = 1'b1;
                is_srl   = 1'b1;
                comb_val = op_a;
            end
            default:  comb_val = '0;
        endcase
    end

    // One-bit step of the working register in the captured direction.
    always_comb begin
        work_next = shift_right ? (work >> 1) : (work << 1);
    end

    // Control FSM with registered result, zero flag and valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            work        <= '0;
            cnt         <= '0;
            shift_right <= 1'b0;
            result      <= '0;
            zero        <= 1'b1;
            valid_out   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (valid_in) begin
                        if (is_shift && (shamt != 5'd0)) begin
                            work        <= op_a;
                            cnt         <= shamt;
                            shift_right <= is_srl;
                            state       <= SHIFT;
                        end else begin
                            result    <= comb_val;
                            zero      <= (comb_val == '0);
                            valid_out <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        result    <= work_next;
                        zero      <= (work_next == '0);
                        valid_out <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: scoreboard bench for alu_iter.

`ifndef ALU_CONTROL_WIDTH
`define ALU_CONTROL_WIDTH 4
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_XOR  4'd2
`define ALU_OR   4'd3
`define ALU_AND  4'd4
`define ALU_SLL  4'd5
`define ALU_SRL  4'd6
`define ALU_LT   4'd7
`define ALU_NULL 4'd8
`endif

module tb_alu_iter;

    logic                          clk;
    logic                          rst_n;
    logic                          valid_in;
    logic                          ready_in;
    logic [`ALU_CONTROL_WIDTH-1:0] alu_ctl;
    logic [31:0]                   op_a;
    logic [31:0]                   op_b;
    logic                          valid_out;
    logic [31:0]                   result;
    logic                          zero;

    logic [31:0] exp_q[$];
    int          checks;
    int          failures;

    alu_iter #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .ALU_ctl   (alu_ctl),
        .op_a      (op_a),
        .op_b      (op_b),
        .valid_out (valid_out),
        .result    (result),
        .zero      (zero)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model.
    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        case (c)
            `ALU_ADD: return a + b;
            `ALU_SUB: return a - b;
            `ALU_XOR: return a ^ b;
            `ALU_OR:  return a | b;
            `ALU_AND: return a & b;
            `ALU_LT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            `ALU_SLL: return a << b[4:0];
            `ALU_SRL: return a >> b[4:0];
            default:  return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
        if ((c == `ALU_SLL || c == `ALU_SRL) && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
    endfunction

    // Scoreboard: every valid_out pops one expected result.
    always @(posedge clk) begin
        #1;
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid_out", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("result", result, e);
                check("zero", {31'd0, zero}, {31'd0, (e == 32'd0)});
            end
        end
    end

    // Single operation: drive, wait for acceptance, measure latency and the
    // number of cycles ready_in stays low. Optionally pulse valid_in mid-shift.
    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input bit pulse_mid);
        int k;
        int low_cnt;
        int lat;
        lat = model_lat(c, b);
        @(negedge clk);
        valid_in = 1'b1;
        alu_ctl  = c;
        op_a     = a;
        op_b     = b;
        check("ready_before_accept", {31'd0, ready_in}, 32'd1);
        exp_q.push_back(model(c, a, b));
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        alu_ctl  = `ALU_ADD;
        k        = 1;
        low_cnt  = 0;
        while (!valid_out && k < 100) begin
            if (!ready_in) low_cnt++;
            if (pulse_mid && k == 3) valid_in = 1'b1;
            if (pulse_mid && k == 4) valid_in = 1'b0;
            @(posedge clk);
            #1;
            k++;
        end
        valid_in = 1'b0;
        check("latency", k, lat);
        check("ready_low_cycles", low_cnt, lat - 1);
        @(posedge clk);
        #1;
        check("valid_pulse_width", {31'd0, valid_out}, 32'd0);
    endtask

    initial begin
        logic [3:0] rc;
        logic [3:0] b2b_ctl[4];
        logic [31:0] ra;
        logic [31:0] rb;
        int waited;
        checks   = 0;
        failures = 0;
        valid_in = 1'b0;
        alu_ctl  = `ALU_NULL;
        op_a     = 32'd0;
        op_b     = 32'd0;
        rst_n    = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", {31'd0, valid_out}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_ready_in", {31'd0, ready_in}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        do_op(`ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op(`ALU_LT,  32'hFFFF_FFFE, 32'd1, 1'b0);
        do_op(`ALU_SUB, 32'd5, 32'd5, 1'b0);
        do_op(`ALU_SLL, 32'h0000_0001, 32'h0000_003F, 1'b1);
        do_op(`ALU_SRL, 32'h8000_0000, 32'd0, 1'b0);
        do_op(`ALU_SRL, 32'h8000_0000, 32'd4, 1'b0);
        do_op(`ALU_LT,  32'd1, 32'hFFFF_FFFE, 1'b0);
        do_op(4'hF, 32'h1234_5678, 32'h1, 1'b0);

        // Back-to-back single-cycle ops with valid_in held high.
        b2b_ctl[0] = `ALU_XOR;
        b2b_ctl[1] = `ALU_OR;
        b2b_ctl[2] = `ALU_AND;
        b2b_ctl[3] = `ALU_NULL;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            alu_ctl  = b2b_ctl[i];
            op_a     = 32'hF0F0_1234 + i;
            op_b     = 32'h0FF0_4321;
            exp_q.push_back(model(b2b_ctl[i], op_a, op_b));
            @(posedge clk);
            #1;
            check("b2b_valid_out", {31'd0, valid_out}, 32'd1);
        end
        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_end_idle", {31'd0, valid_out}, 32'd0);

        // Reset mid-shift aborts the operation.
        @(negedge clk);
        valid_in = 1'b1;
        alu_ctl  = `ALU_SLL;
        op_a     = 32'h0000_0003;
        op_b     = 32'd10;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready_in", {31'd0, ready_in}, 32'd1);
        check("abort_valid_out", {31'd0, valid_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        waited = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (valid_out) waited++;
        end
        check("abort_no_valid", waited, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_zero", {31'd0, zero}, 32'd1);
        do_op(`ALU_ADD, 32'd100, 32'd23, 1'b0);

        // Random mix.
        for (int i = 0; i < 20; i++) begin
            rc = 4'($urandom_range(0, 9));
            ra = $urandom;
            rb = $urandom;
            if (rc == `ALU_SLL || rc == `ALU_SRL) rb[4:0] = 5'($urandom_range(0, 12));
            do_op(rc, ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
